// File: rtl/pkt_depacketizer.sv
// pkt_depacketizer
//   Memory-wrapper-side receiver for PE-to-memory packets. Accepts packets from
//   the network, keeps data packets addressed to this node, drops everything
//   else, and buffers {src, payload} in a small circular FIFO for the write path.
//
//   Optional feature macro: PKT_DEPKT_ERRCNT_EN adds the saturating
//   drop_count_o port and its counter.
//
// Ports
//   clk_i          clock, all state updates on the rising edge
//   reset_i        synchronous, active-high reset
//   pkt_in_i       packet: [32] type (0 = data), [31:28] dest, [27:24] src, [23:0] payload
//   pkt_valid_i    pkt_in_i valid
//   pkt_ready_o    block can accept a packet (FIFO not full)
//   data_out_o     payload at FIFO head
//   src_addr_o     source PE address of head entry
//   out_valid_o    FIFO non-empty
//   out_ready_i    consumer takes head entry
//   drop_pulse_o   one-cycle pulse per dropped packet
//   drop_count_o   saturating dropped-packet count (PKT_DEPKT_ERRCNT_EN only)

module pkt_depacketizer #(
    parameter int unsigned                  PACKET_WIDTH = 33,
    parameter int unsigned                  DATA_WIDTH   = 24,
    parameter int unsigned                  ADDR_WIDTH   = 4,
    parameter logic [ADDR_WIDTH-1:0]        MY_ADDR      = ADDR_WIDTH'(13),
    parameter int unsigned                  FIFO_DEPTH   = 4
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic [PACKET_WIDTH-1:0] pkt_in_i,
    input  logic                    pkt_valid_i,
    output logic                    pkt_ready_o,
    output logic [DATA_WIDTH-1:0]   data_out_o,
    output logic [ADDR_WIDTH-1:0]   src_addr_o,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic                    drop_pulse_o
`ifdef PKT_DEPKT_ERRCNT_EN
    ,
    output logic [7:0]              drop_count_o
`endif
);

    localparam int unsigned IDX_W = $clog2(FIFO_DEPTH);
    localparam int unsigned PTR_W = IDX_W + 1;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] src;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    entry_t           mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] count_q, count_d;
    logic             pkt_ready_q, pkt_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             drop_pulse_q, drop_pulse_d;

    logic             is_data_c;
    logic             accept_c;
    logic             push_c;
    logic             drop_c;
    logic             pop_c;
    entry_t           wr_entry_c;

    // Packet classification and handshakes
    always_comb begin
        is_data_c  = ~pkt_in_i[PACKET_WIDTH-1]
                   && (pkt_in_i[PACKET_WIDTH-2 -: ADDR_WIDTH] == MY_ADDR);
        accept_c   = pkt_valid_i && pkt_ready_q;
        push_c     = accept_c && is_data_c;
        drop_c     = accept_c && !is_data_c;
        pop_c      = out_valid_q && out_ready_i;
        wr_entry_c = '{src:  pkt_in_i[DATA_WIDTH +: ADDR_WIDTH],
                       data: pkt_in_i[DATA_WIDTH-1:0]};
    end

    // Pointer, occupancy and flag next-state; flags decode the next count so
    // pkt_ready/out_valid are registered with no path from out_ready_i
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        pkt_ready_d  = pkt_ready_q;
        out_valid_d  = out_valid_q;
        drop_pulse_d = drop_c;

        if (push_c) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (pop_c) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        end

        case ({push_c, pop_c})
            2'b10:   count_d = count_q + PTR_W'(1);
            2'b01:   count_d = count_q - PTR_W'(1);
            default: count_d = count_q;
        endcase

        pkt_ready_d = (count_d != PTR_W'(FIFO_DEPTH));
        out_valid_d = (count_d != '0);
    end

    // State registers and FIFO storage
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            pkt_ready_q  <= 1'b1;
            out_valid_q  <= 1'b0;
            drop_pulse_q <= 1'b0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            pkt_ready_q  <= pkt_ready_d;
            out_valid_q  <= out_valid_d;
            drop_pulse_q <= drop_pulse_d;
            if (push_c) begin
                mem_q[wr_ptr_q[IDX_W-1:0]] <= wr_entry_c;
            end
        end
    end

`ifdef PKT_DEPKT_ERRCNT_EN
    logic [7:0] drop_count_q, drop_count_d;

    // Saturating drop counter, cleared only by reset
    always_comb begin
        drop_count_d = drop_count_q;
        if (drop_c && (drop_count_q != 8'hFF)) begin
            drop_count_d = drop_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            drop_count_q <= '0;
        end else begin
            drop_count_q <= drop_count_d;
        end
    end

    assign drop_count_o = drop_count_q;
`endif

    // Head entry is read straight from storage so it holds while stalled
    assign data_out_o   = mem_q[rd_ptr_q[IDX_W-1:0]].data;
    assign src_addr_o   = mem_q[rd_ptr_q[IDX_W-1:0]].src;
    assign pkt_ready_o  = pkt_ready_q;
    assign out_valid_o  = out_valid_q;
    assign drop_pulse_o = drop_pulse_q;

endmodule

// File: tb/tb_pkt_depacketizer.sv
// Self-checking bench for pkt_depacketizer: directed scenarios plus random
// traffic compared against a queue-based behavioural model.
module tb_pkt_depacketizer;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [32:0] pkt_in;
    logic        pkt_valid;
    logic        pkt_ready;
    logic [23:0] data_out;
    logic [3:0]  src_addr;
    logic        out_valid;
    logic        out_ready;
    logic        drop_pulse;
`ifdef PKT_DEPKT_ERRCNT_EN
    logic [7:0]  drop_count;
`endif

    always #5 clk = ~clk;

    pkt_depacketizer dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .pkt_in_i     (pkt_in),
        .pkt_valid_i  (pkt_valid),
        .pkt_ready_o  (pkt_ready),
        .data_out_o   (data_out),
        .src_addr_o   (src_addr),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .drop_pulse_o (drop_pulse)
`ifdef PKT_DEPKT_ERRCNT_EN
        ,
        .drop_count_o (drop_count)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model: in-order queue of accepted entries plus drop bookkeeping
    typedef struct {
        logic [3:0]  src;
        logic [23:0] data;
    } ent_t;
    ent_t mq[$];
    logic exp_drop = 1'b0;
    int   exp_cnt  = 0;
    bit   last_acc = 1'b0;

    function automatic logic [32:0] mk(input logic t, input logic [3:0] d,
                                       input logic [3:0] s, input logic [23:0] p);
        return {t, d, s, p};
    endfunction

    // Drive one cycle of inputs, advance the model across the edge, return at negedge
    task automatic drive(input logic rst, input logic v, input logic [32:0] p, input logic ordy);
        bit acc, pop, isdat;
        reset     = rst;
        pkt_valid = v;
        pkt_in    = p;
        out_ready = ordy;
        if (rst) begin
            mq.delete();
            exp_drop = 1'b0;
            exp_cnt  = 0;
            last_acc = 1'b0;
        end else begin
            acc   = v && (mq.size() < DEPTH);
            pop   = (mq.size() != 0) && ordy;
            isdat = !p[32] && (p[31:28] == 4'hD);
            if (pop) mq.delete(0);
            if (acc && isdat) mq.push_back('{src: p[27:24], data: p[23:0]});
            exp_drop = acc && !isdat;
            if (exp_drop && exp_cnt < 255) exp_cnt++;
            last_acc = acc;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b0, '0, 1'b0);
        drive(1'b1, 1'b0, '0, 1'b0);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (pkt_ready !== 1'b1) begin errors++; $display("FAIL reset_pkt_ready got %b expected 1", pkt_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b expected 0", out_valid); end
        checks++; if (data_out !== 24'h0) begin errors++; $display("FAIL reset_data_out got %h expected 000000", data_out); end
        checks++; if (src_addr !== 4'h0) begin errors++; $display("FAIL reset_src_addr got %h expected 0", src_addr); end
        checks++; if (drop_pulse !== 1'b0) begin errors++; $display("FAIL reset_drop_pulse got %b expected 0", drop_pulse); end
`ifdef PKT_DEPKT_ERRCNT_EN
        checks++; if (drop_count !== 8'd0) begin errors++; $display("FAIL reset_drop_count got %0d expected 0", drop_count); end
`endif
    endtask

    task automatic test_first_packet();
        drive(1'b0, 1'b1, mk(1'b0, 4'hD, 4'h6, 24'h030201), 1'b1);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL first_out_valid got %b expected 1", out_valid); end
        checks++; if (data_out !== 24'h030201) begin errors++; $display("FAIL first_data got %h expected 030201", data_out); end
        checks++; if (src_addr !== 4'h6) begin errors++; $display("FAIL first_src got %h expected 6", src_addr); end
        checks++; if (drop_pulse !== 1'b0) begin errors++; $display("FAIL first_drop_pulse got %b expected 0", drop_pulse); end
        drive(1'b0, 1'b0, '0, 1'b1);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL first_drain got %b expected 0", out_valid); end
    endtask

    task automatic test_drop();
        do_reset();
        drive(1'b0, 1'b1, mk(1'b0, 4'h5, 4'h1, 24'h111111), 1'b1);
        checks++; if (drop_pulse !== 1'b1) begin errors++; $display("FAIL drop_pulse_misroute got %b expected 1", drop_pulse); end
        checks++; if (pkt_ready !== 1'b1) begin errors++; $display("FAIL drop_ready got %b expected 1", pkt_ready); end
        drive(1'b0, 1'b1, mk(1'b1, 4'hD, 4'h2, 24'h222222), 1'b1);
        checks++; if (drop_pulse !== 1'b1) begin errors++; $display("FAIL drop_pulse_type got %b expected 1", drop_pulse); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drop_out_valid got %b expected 0", out_valid); end
        drive(1'b0, 1'b0, '0, 1'b1);
        checks++; if (drop_pulse !== 1'b0) begin errors++; $display("FAIL drop_pulse_end got %b expected 0", drop_pulse); end
`ifdef PKT_DEPKT_ERRCNT_EN
        checks++; if (drop_count !== 8'd2) begin errors++; $display("FAIL drop_count got %0d expected 2", drop_count); end
`endif
    endtask

    task automatic test_backpressure();
        int n = 0;
        do_reset();
        for (int c = 0; c < 20 && n < 4; c++) begin
            drive(1'b0, 1'b1, mk(1'b0, 4'hD, 4'h2, 24'(n + 1)), 1'b0);
            if (last_acc) n++;
        end
        checks++; if (n != 4) begin errors++; $display("FAIL bp_accept_timeout got %0d expected 4", n); end
        checks++; if (pkt_ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready got %b expected 0", pkt_ready); end
        // 5th packet waits while full
        drive(1'b0, 1'b1, mk(1'b0, 4'hD, 4'h2, 24'd5), 1'b0);
        checks++; if (pkt_ready !== 1'b0 || data_out !== 24'd1) begin errors++; $display("FAIL bp_hold got ready=%b data=%h expected ready=0 data=000001", pkt_ready, data_out); end
        // First pop in the full cycle
        drive(1'b0, 1'b1, mk(1'b0, 4'hD, 4'h2, 24'd5), 1'b1);
        checks++; if (pkt_ready !== 1'b1) begin errors++; $display("FAIL bp_reassert got %b expected 1", pkt_ready); end
        checks++; if (data_out !== 24'd2) begin errors++; $display("FAIL bp_pop2 got %h expected 000002", data_out); end
        drive(1'b0, 1'b1, mk(1'b0, 4'hD, 4'h2, 24'd5), 1'b1);
        for (int e = 3; e <= 5; e++) begin
            checks++; if (out_valid !== 1'b1 || data_out !== 24'(e)) begin errors++; $display("FAIL bp_order got valid=%b data=%h expected valid=1 data=%h", out_valid, data_out, 24'(e)); end
            drive(1'b0, 1'b0, '0, 1'b1);
        end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty got %b expected 0", out_valid); end
    endtask

    task automatic test_stream();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 1'b1, mk(1'b0, 4'hD, 4'(i), 24'h100 + 24'(i)), 1'b1);
            checks++; if (out_valid !== 1'b1 || data_out !== 24'h100 + 24'(i) || src_addr !== 4'(i) || pkt_ready !== 1'b1) begin
                errors++; $display("FAIL stream_%0d got valid=%b data=%h src=%h ready=%b expected 1 %h %h 1", i, out_valid, data_out, src_addr, pkt_ready, 24'h100 + 24'(i), 4'(i));
            end
        end
        drive(1'b0, 1'b0, '0, 1'b1);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_drain got %b expected 0", out_valid); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, mk(1'b0, 4'hD, 4'h9, 24'hA1 + 24'(i)), 1'b0);
        drive(1'b0, 1'b1, mk(1'b0, 4'h7, 4'h9, 24'hBAD), 1'b0);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_prefill got %b expected 1", out_valid); end
        drive(1'b1, 1'b1, mk(1'b0, 4'hD, 4'h9, 24'hDEAD), 1'b0);
        reset = 1'b0;
        checks++; if (out_valid !== 1'b0 || pkt_ready !== 1'b1 || drop_pulse !== 1'b0) begin
            errors++; $display("FAIL mid_reset got valid=%b ready=%b drop=%b expected 0 1 0", out_valid, pkt_ready, drop_pulse);
        end
`ifdef PKT_DEPKT_ERRCNT_EN
        checks++; if (drop_count !== 8'd0) begin errors++; $display("FAIL mid_drop_count got %0d expected 0", drop_count); end
`endif
        drive(1'b0, 1'b1, mk(1'b0, 4'hD, 4'h3, 24'hABCDEF), 1'b1);
        checks++; if (out_valid !== 1'b1 || data_out !== 24'hABCDEF || src_addr !== 4'h3) begin
            errors++; $display("FAIL mid_new got valid=%b data=%h src=%h expected 1 abcdef 3", out_valid, data_out, src_addr);
        end
        drive(1'b0, 1'b0, '0, 1'b1);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_alone got %b expected 0", out_valid); end
    endtask

    task automatic test_saturation();
        int pulses = 0;
        do_reset();
        for (int i = 0; i < 260; i++) begin
            drive(1'b0, 1'b1, mk(1'b0, 4'h5, 4'h1, 24'(i)), 1'b1);
            if (drop_pulse === 1'b1) pulses++;
        end
        drive(1'b0, 1'b0, '0, 1'b1);
        checks++; if (pulses != 260) begin errors++; $display("FAIL sat_pulses got %0d expected 260", pulses); end
`ifdef PKT_DEPKT_ERRCNT_EN
        checks++; if (drop_count !== 8'd255) begin errors++; $display("FAIL sat_count got %0d expected 255", drop_count); end
`endif
    endtask

    task automatic test_random();
        logic [3:0] dest;
        do_reset();
        for (int c = 0; c < 500; c++) begin
            dest = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hD;
            drive(1'b0, 1'($urandom_range(0, 3) != 0),
                  mk(1'($urandom_range(0, 7) == 0), dest, 4'($urandom), 24'($urandom)),
                  1'($urandom_range(0, 2) != 0));
            checks++; if (out_valid !== (mq.size() != 0)) begin errors++; $display("FAIL rnd_valid cyc %0d got %b expected %b", c, out_valid, mq.size() != 0); end
            checks++; if (pkt_ready !== (mq.size() < DEPTH)) begin errors++; $display("FAIL rnd_ready cyc %0d got %b expected %b", c, pkt_ready, mq.size() < DEPTH); end
            checks++; if (drop_pulse !== exp_drop) begin errors++; $display("FAIL rnd_drop cyc %0d got %b expected %b", c, drop_pulse, exp_drop); end
            if (mq.size() != 0) begin
                checks++; if (data_out !== mq[0].data || src_addr !== mq[0].src) begin
                    errors++; $display("FAIL rnd_head cyc %0d got %h/%h expected %h/%h", c, data_out, src_addr, mq[0].data, mq[0].src);
                end
            end
`ifdef PKT_DEPKT_ERRCNT_EN
            checks++; if (drop_count !== 8'(exp_cnt)) begin errors++; $display("FAIL rnd_count cyc %0d got %0d expected %0d", c, drop_count, exp_cnt); end
`endif
        end
    endtask

    initial begin
        reset     = 1'b1;
        pkt_valid = 1'b0;
        pkt_in    = '0;
        out_ready = 1'b0;
        test_reset();
        test_first_packet();
        test_drop();
        test_backpressure();
        test_stream();
        test_reset_mid();
        test_saturation();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
